// File: rtl/wbdbgbus_fifo_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ packet streams.
// A grant is held until the word flagged last transfers, or until the owner idles for TIMEOUT cycles.
module wbdbgbus_fifo_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 36,
  parameter int TIMEOUT = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ-1:0]       i_req_last,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_fifo_wr_en,
  output logic [WIDTH-1:0]         o_fifo_wr_data,
  input  logic                     i_fifo_full,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic                     o_busy,
  output logic                     o_abort
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [PW-1:0] IDX_MAX  = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [0:0]         state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gnt_idx;
  logic [CW-1:0]      idle_cnt;

  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      nxt_ptr;
  logic               gnt_valid;
  logic               gnt_last;
  logic               fire;
  logic [WIDTH-1:0]   mux_data;

  // Handshake: a word moves when i_req_valid[k] and o_req_ready[k] are both high
  // at a rising edge; ready never depends on valid, and a non-granted slot must hold.
  assign o_busy      = (state == ST_BUSY);
  assign o_req_ready = (o_busy && !i_fifo_full) ? o_grant : '0;
  assign gnt_valid   = |(i_req_valid & o_grant);
  assign gnt_last    = |(i_req_last & o_grant);
  assign fire        = |(i_req_valid & o_req_ready);
  assign nxt_ptr     = (gnt_idx == IDX_MAX) ? '0 : gnt_idx + 1'b1;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    cand       = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && i_req_valid[cand]) begin
        pick_found    = 1'b1;
        pick_idx      = cand;
        pick_oh[cand] = 1'b1;
      end
      cand = (cand == IDX_MAX) ? '0 : cand + 1'b1;
    end
  end

  // AND-OR mux keyed by the one-hot grant; forced to zero when nothing is written.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      mux_data = mux_data | ({WIDTH{o_grant[k]}} & i_req_data[k*WIDTH +: WIDTH]);
    end
  end

  assign o_fifo_wr_en   = fire;
  assign o_fifo_wr_data = fire ? mux_data : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      o_grant  <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
      o_abort  <= 1'b0;
    end else begin
      o_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state    <= ST_BUSY;
            o_grant  <= pick_oh;
            gnt_idx  <= pick_idx;
            idle_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (fire) begin
            idle_cnt <= '0;
            if (gnt_last) begin
              state   <= ST_IDLE;
              o_grant <= '0;
              rr_ptr  <= nxt_ptr;
            end
          end else if (!gnt_valid) begin
            // A full FIFO stalls without counting; only a silent owner ages out.
            if (idle_cnt == CNT_LAST) begin
              state    <= ST_IDLE;
              o_grant  <= '0;
              rr_ptr   <= nxt_ptr;
              idle_cnt <= '0;
              o_abort  <= 1'b1;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_grant <= '0;
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n) $onehot0(o_grant));
  a_busy_grant:   assert property (@(posedge i_clk) disable iff (!i_rst_n) o_busy == (|o_grant));
  a_no_full_wr:   assert property (@(posedge i_clk) disable iff (!i_rst_n) !(o_fifo_wr_en && i_fifo_full));

endmodule

// File: tb/tb_wbdbgbus_fifo_arb.sv
// Directed bench for wbdbgbus_fifo_arb: per-requester word queues, a FIFO occupancy
// model with stallable reader, and a write-side scoreboard fed with hand-ordered words.
module tb_wbdbgbus_fifo_arb;
  localparam int NR    = 4;
  localparam int W     = 36;
  localparam int TO    = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_last;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   o_req_ready;
  logic            o_fifo_wr_en;
  logic [W-1:0]    o_fifo_wr_data;
  logic            fifo_full;
  logic [NR-1:0]   o_grant;
  logic            o_busy;
  logic            o_abort;

  int checks     = 0;
  int failures   = 0;
  int n_wr       = 0;
  int n_abort    = 0;
  int fifo_occ   = 0;
  int rd_pending = 0;
  bit auto_rd    = 1'b1;

  logic [W:0]   rq0[$];
  logic [W:0]   rq1[$];
  logic [W:0]   rq2[$];
  logic [W:0]   rq3[$];
  logic [W-1:0] exp_q[$];

  wbdbgbus_fifo_arb #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .i_req_last     (req_last),
    .i_req_data     (req_data),
    .o_req_ready    (o_req_ready),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .o_fifo_wr_data (o_fifo_wr_data),
    .i_fifo_full    (fifo_full),
    .o_grant        (o_grant),
    .o_busy         (o_busy),
    .o_abort        (o_abort)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // requester queues: entry = {last, data}
  function automatic int qsize(input int k);
    case (k)
      0:       return rq0.size();
      1:       return rq1.size();
      2:       return rq2.size();
      default: return rq3.size();
    endcase
  endfunction

  function automatic logic [W:0] qhead(input int k);
    case (k)
      0:       return rq0[0];
      1:       return rq1[0];
      2:       return rq2[0];
      default: return rq3[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0:       void'(rq0.pop_front());
      1:       void'(rq1.pop_front());
      2:       void'(rq2.pop_front());
      default: void'(rq3.pop_front());
    endcase
  endtask

  task automatic push_word(input int k, input logic last, input logic [W-1:0] d);
    case (k)
      0:       rq0.push_back({last, d});
      1:       rq1.push_back({last, d});
      2:       rq2.push_back({last, d});
      default: rq3.push_back({last, d});
    endcase
  endtask

  function automatic int pending();
    return qsize(0) + qsize(1) + qsize(2) + qsize(3);
  endfunction

  // driver: sample handshakes mid-cycle, retire and re-present just after the edge
  initial begin
    logic [NR-1:0] fire_s;
    logic          wr_s;
    logic [W:0]    h;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      fire_s = req_valid & o_req_ready;
      wr_s   = o_fifo_wr_en;
      @(posedge clk);
      #1;
      for (int k = 0; k < NR; k++) if (fire_s[k]) qpop(k);
      if (wr_s) fifo_occ++;
      if (rd_pending > 0 && fifo_occ > 0) begin
        fifo_occ--;
        rd_pending--;
      end else if (auto_rd && fifo_occ > 0) begin
        fifo_occ--;
      end
      fifo_full = (fifo_occ >= DEPTH);
      for (int k = 0; k < NR; k++) begin
        if (qsize(k) > 0) begin
          h = qhead(k);
          req_valid[k]       = 1'b1;
          req_last[k]        = h[W];
          req_data[k*W +: W] = h[W-1:0];
        end else begin
          req_valid[k]       = 1'b0;
          req_last[k]        = 1'b0;
          req_data[k*W +: W] = '0;
        end
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && o_fifo_wr_en) begin
      n_wr++;
      check("wr_while_full", {63'd0, fifo_full}, 64'd0);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=%0h required=none", o_fifo_wr_data);
      end else begin
        e = exp_q.pop_front();
        if (o_fifo_wr_data !== e) begin
          failures++;
          $display("FAIL wr_data actual=%0h required=%0h", o_fifo_wr_data, e);
        end
      end
    end
    if (o_abort) n_abort++;
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((pending() > 0 || o_busy || exp_q.size() > 0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drain"}, {63'd0, (n < 300)}, 64'd1);
  endtask

  initial begin
    int wr0;
    int ab0;
    int t;
    bit found;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_grant", o_grant, 0);
    check("rst_busy", o_busy, 0);
    check("rst_wr_en", o_fifo_wr_en, 0);
    check("rst_ready", o_req_ready, 0);
    check("rst_abort", o_abort, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word from requester 1
    push_word(1, 1'b1, 36'h123456789);
    exp_q.push_back(36'h123456789);
    @(negedge clk);
    check("t1_grant_pre", o_grant, 0);
    @(negedge clk);
    check("t1_grant", o_grant, 4'b0010);
    check("t1_wr_en", o_fifo_wr_en, 1);
    check("t1_ready", o_req_ready, 4'b0010);
    @(negedge clk);
    check("t1_idle_busy", o_busy, 0);
    check("t1_idle_grant", o_grant, 0);
    wait_idle("t1");

    // round robin from rr_ptr=2: 2,3,0,1,2,3,0,1
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++)
        push_word(k, 1'b1, 36'hA00000000 + 36'(k * 16 + r));
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(36'hA00000000 + 36'(2 * 16 + r));
      exp_q.push_back(36'hA00000000 + 36'(3 * 16 + r));
      exp_q.push_back(36'hA00000000 + 36'(0 * 16 + r));
      exp_q.push_back(36'hA00000000 + 36'(1 * 16 + r));
    end
    wr0 = n_wr;
    repeat (16) @(negedge clk);
    #1;
    check("t2_words_in_16", n_wr - wr0, 8);
    wait_idle("t2");

    // packet atomicity: req0 5 words while req2 waits
    for (int i = 0; i < 5; i++) begin
      push_word(0, (i == 4), 36'hB00000000 + 36'(i));
      exp_q.push_back(36'hB00000000 + 36'(i));
    end
    @(negedge clk);
    push_word(2, 1'b1, 36'hC22222222);
    exp_q.push_back(36'hC22222222);
    @(negedge clk);
    check("t3_grant", o_grant, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      check("t3_ready2_blocked", o_req_ready[2], 0);
      @(negedge clk);
    end
    wait_idle("t3");

    // full backpressure with reader stalled
    repeat (4) @(negedge clk);
    auto_rd = 1'b0;
    ab0 = n_abort;
    for (int i = 0; i < 6; i++) begin
      push_word(3, (i == 5), 36'h300000000 + 36'(i));
      exp_q.push_back(36'h300000000 + 36'(i));
    end
    repeat (20) @(negedge clk);
    check("t4_occ_full", fifo_occ, DEPTH);
    check("t4_wr_en_stalled", o_fifo_wr_en, 0);
    check("t4_ready_stalled", o_req_ready, 0);
    check("t4_grant_held", o_grant, 4'b1000);
    rd_pending = 2;
    wait_idle("t4");
    check("t4_occ_after", fifo_occ, DEPTH);
    check("t4_no_abort", n_abort - ab0, 0);
    auto_rd = 1'b1;
    repeat (6) @(negedge clk);

    // timeout abort: req0 sends 2 words without last, req2 waits
    push_word(0, 1'b0, 36'hD00000000);
    push_word(0, 1'b0, 36'hD00000001);
    push_word(2, 1'b1, 36'hE00000002);
    exp_q.push_back(36'hD00000000);
    exp_q.push_back(36'hD00000001);
    exp_q.push_back(36'hE00000002);
    t = 0;
    found = 1'b0;
    while (!found && t < 40) begin
      @(negedge clk);
      t++;
      if (o_abort) found = 1'b1;
    end
    check("t5_abort_delay", t, 12);
    check("t5_abort_grant", o_grant, 0);
    @(negedge clk);
    check("t5_abort_width", o_abort, 0);
    check("t5_next_grant", o_grant, 4'b0100);
    wait_idle("t5");

    // async reset mid-packet, then arbitration from rr_ptr=0
    push_word(1, 1'b0, 36'hF00000000);
    push_word(1, 1'b0, 36'hF00000001);
    push_word(1, 1'b1, 36'hF00000002);
    exp_q.push_back(36'hF00000000);
    @(negedge clk);
    @(negedge clk);
    check("t6_grant", o_grant, 4'b0010);
    check("t6_wr_en", o_fifo_wr_en, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", o_grant, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_wr_en", o_fifo_wr_en, 0);
    check("t6_rst_ready", o_req_ready, 0);
    rq1.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_word(1, 1'b1, 36'h111111111);
    push_word(3, 1'b1, 36'h333333333);
    exp_q.push_back(36'h111111111);
    exp_q.push_back(36'h333333333);
    @(negedge clk);
    @(negedge clk);
    check("t6_rr_restart", o_grant, 4'b0010);
    wait_idle("t6");

    check("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
